// File: rtl/ps_tx_sched_if.sv
// Requester-side bundle for ps_tx_sched: byte request handshake in, serial lane out.
interface ps_tx_sched_if #(
  parameter int N_REQ = 4,
  parameter int SRC_W = $clog2(N_REQ)
);
  logic                 i_en;
  logic [N_REQ-1:0]     i_req_valid;
  logic [8*N_REQ-1:0]   i_req_data;
  logic [N_REQ-1:0]     o_req_ready;
  logic                 o_sdata;
  logic                 o_sframe;
  logic                 o_sync;
  logic [SRC_W-1:0]     o_src;
  logic                 o_busy;

  modport master (
    output i_en, i_req_valid, i_req_data,
    input  o_req_ready, o_sdata, o_sframe, o_sync, o_src, o_busy
  );

  modport slave (
    input  i_en, i_req_valid, i_req_data,
    output o_req_ready, o_sdata, o_sframe, o_sync, o_src, o_busy
  );
endinterface

// File: rtl/ps_tx_sched.sv
// Round-robin byte scheduler feeding one LSB-first serial lane; first bit 1 cycle after accept.
// Requesters wait on o_req_ready, which only rises in IDLE or on the last bit when frames run back-to-back.
module ps_tx_sched #(
  parameter int N_REQ   = 4,
  parameter int GAP_CYC = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ps_tx_sched_if.slave  bus
);
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] rr_q, rr_d;
  logic             sdata_q, sdata_d;
  logic             sframe_q, sframe_d;
  logic             sync_q, sync_d;
  logic             busy_q, busy_d;

  logic             grant_ok;
  logic             found;
  logic             accept;
  logic [N_REQ-1:0] gnt;
  logic [SRC_W-1:0] gidx;
  logic [SRC_W-1:0] idx;
  logic [7:0]       gdata;
  logic [7:0]       req_byte [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_byte
    assign req_byte[g] = bus.i_req_data[8*g +: 8];
  end

  assign grant_ok = bus.i_en &&
                    ((state_q == ST_IDLE) ||
                     (state_q == ST_SHIFT && bcnt_q == 3'd7 && GAP_CYC == 0));

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = SRC_W'((int'(rr_q) + i) % N_REQ);
      if (!found && bus.i_req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = idx;
        found    = 1'b1;
      end
    end
  end

  assign bus.o_req_ready = grant_ok ? gnt : '0;
  assign accept          = grant_ok && found;
  assign gdata           = req_byte[gidx];

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    gcnt_d   = gcnt_q;
    sh_d     = sh_q;
    src_d    = src_q;
    rr_d     = rr_q;
    sdata_d  = 1'b0;
    sframe_d = 1'b0;
    sync_d   = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (bcnt_q != 3'd7) begin
          bcnt_d   = bcnt_q + 3'd1;
          sdata_d  = sh_q[bcnt_d];
          sframe_d = 1'b1;
          sync_d   = (bcnt_d == 3'd7);
        end else if (GAP_CYC > 0) begin
          state_d = ST_GAP;
          gcnt_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gcnt_q == GAP_LAST) state_d = ST_IDLE;
        else                    gcnt_d  = gcnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // An accept overrides the SHIFT-end decision, giving back-to-back frames.
    if (accept) begin
      state_d  = ST_SHIFT;
      sh_d     = gdata;
      src_d    = gidx;
      bcnt_d   = 3'd0;
      rr_d     = (gidx == SRC_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      sdata_d  = gdata[0];
      sframe_d = 1'b1;
      sync_d   = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      bcnt_q   <= '0;
      gcnt_q   <= '0;
      sh_q     <= '0;
      src_q    <= '0;
      rr_q     <= '0;
      sdata_q  <= 1'b0;
      sframe_q <= 1'b0;
      sync_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      gcnt_q   <= gcnt_d;
      sh_q     <= sh_d;
      src_q    <= src_d;
      rr_q     <= rr_d;
      sdata_q  <= sdata_d;
      sframe_q <= sframe_d;
      sync_q   <= sync_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_sdata  = sdata_q;
  assign bus.o_sframe = sframe_q;
  assign bus.o_sync   = sync_q;
  assign bus.o_src    = src_q;
  assign bus.o_busy   = busy_q;
endmodule

// File: doc/ps_tx_sched.md
# ps_tx_sched

Round-robin scheduler that shares one 8-bit parallel-to-serial lane between `N_REQ` byte requesters. It grants one requester per frame and captures that requester's byte. It shifts the byte out LSB-first, one bit per clock, with frame and last-bit markers. It sits between the block-level byte producers and the serial pin driver.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `GAP_CYC`, default 1: idle cycles inserted between frames, 0..15.
- `SRC_W`, default `$clog2(N_REQ)`: width of the source-id output. Derived; not overridden.

- `i_clk` in 1: single clock; every register is clocked on its rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_en` in 1: global enable; while low, no new grant is issued.
- `i_req_valid` in `N_REQ`: bit k is high when requester k has a byte pending.
- `i_req_data` in `8*N_REQ`: requester k's byte on `[8k+7:8k]`; must be stable while `i_req_valid[k]` is high.
- `o_req_ready` out `N_REQ`: one-hot grant; the byte is accepted in a cycle where `valid[k] & ready[k]`.
- `o_sdata` out 1: serial bit, LSB first; 0 when not framing.
- `o_sframe` out 1: high on each of the 8 bit cycles.
- `o_sync` out 1: high only on bit 7, the last bit of a frame.
- `o_src` out `SRC_W`: id of the requester whose byte is on `o_sdata`; holds its last value between frames.
- `o_busy` out 1: high in SHIFT and GAP.

## Operation
- FSM states:
  - IDLE: no frame in progress.
  - SHIFT: 8 bit cycles, tracked by a 3-bit counter `bcnt`.
  - GAP: `GAP_CYC` cycles, tracked by a 4-bit counter.
- Grant condition, `grant_ok`:
  - true in IDLE when `i_en` is high;
  - true in SHIFT when `bcnt==7`, `GAP_CYC==0` and `i_en` is high (back-to-back frames).
- `o_req_ready` is combinational. It is the one-hot of the first set bit of `i_req_valid`, searched circularly from pointer `rr_ptr`, gated by `grant_ok`. It is all-zero otherwise.
- On an accept of requester k:
  - the shift register loads `i_req_data[k]`;
  - `o_src` is set to k;
  - `bcnt` is set to 0;
  - `rr_ptr` is set to (k+1) mod `N_REQ`;
  - the state becomes SHIFT.
- Transitions out of SHIFT, evaluated when `bcnt==7`:
  - to a new SHIFT if an accept occurs;
  - else to GAP if `GAP_CYC>0`;
  - else to IDLE.
- GAP returns to IDLE after `GAP_CYC` cycles. `i_req_valid` is ignored during GAP.
- `i_en` low during SHIFT does not stall the frame. The current byte completes, and no further grant is made.
- A requester that drops valid without being granted loses nothing, because no state is kept per requester. `rr_ptr` advances only on an accept.
- Reset mid-frame: all registers clear asynchronously, the frame is aborted, and no partial byte is replayed.

## Timing
- Reset values:
  - state = IDLE;
  - `o_sdata`, `o_sframe`, `o_sync` and `o_busy` are 0;
  - `o_src` = 0;
  - `rr_ptr` = 0;
  - `o_req_ready` is all-zero (IDLE with no valid).
- Accept at edge t, meaning ready and valid are both high in the cycle before edge t:
  - `o_sframe=1`, `o_sdata=bit0` and `o_busy=1` from edge t;
  - bit n is presented in cycle t+n;
  - `o_sync=1` in cycle t+7 only.
  - Latency from accept to first bit is 1 cycle.
- Frame spacing, measured from the start of one frame to the start of the next:
  - `GAP_CYC==0`: frames start 8 cycles apart, so `o_sframe` stays high continuously.
  - `GAP_CYC>0`: minimum 8+`GAP_CYC`+1 cycles, covering SHIFT, GAP, then the IDLE grant cycle.
- `o_sdata`, `o_sframe`, `o_sync`, `o_src` and `o_busy` are all registered outputs.
- Simultaneous valids: exactly one grant per accept opportunity, chosen by round-robin from `rr_ptr`.

## Test plan
- **Single request, `GAP_CYC=1`, `N_REQ=4`.** Stimulus: reset, then `valid=4'b0001`, data0=8'hA5. Required response:
  - ready[0] is high for one cycle;
  - `o_sdata` reads 1,0,1,0,0,1,0,1 over 8 cycles;
  - `o_sync` is high on the 8th;
  - `o_src=0`;
  - 1 GAP cycle follows, then `o_busy=0`.
- **Round-robin ordering.** Stimulus: all four valid held, data k=8'h10+k. Required response:
  - grant order is 0,1,2,3,0;
  - `o_src` follows that order;
  - each frame carries 8'h10..8'h13.
- **Back-to-back with `GAP_CYC=0`.** Stimulus: req1 and req2 valid. Required response:
  - 16 consecutive `o_sframe=1` cycles;
  - ready[2] is asserted in the cycle where `o_sync` is high for frame 1.
- **Enable drop.** Stimulus: `i_en` deasserted at bit 3 of a frame, req0 still valid. Required response:
  - the frame completes all 8 bits;
  - no ready is asserted while `i_en=0`;
  - a grant occurs 1 cycle after `i_en` returns.
- **Reset mid-frame.** Stimulus: `i_rst_n` pulsed low at bit 4. Required response:
  - all outputs are 0 immediately;
  - after release, req valid=4'b1000 is granted first, since `rr_ptr` is 0 and requesters 0..2 are idle.
- **Late valid.** Stimulus: req2 raises valid during GAP. Required response:
  - no ready during GAP;
  - ready[2] is asserted in the first IDLE cycle.
